dly_cal_ctrl: RTL
=================

DLY_CAL_CTRL -- requirements
Module: dly_cal_ctrl

Interface
REQ-001 Parameter N_CODE, default 6: width of the delay-line control code.
REQ-002 Parameter SETTLE_CYC, default 8: cycles the delay line is allowed to settle after each code change.
REQ-003 Parameter N_AVG, default 16, power of two, at least 2: phase-detector votes per decision.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port start, input, 1: request a new binary search.
REQ-007 Port track_en, input, 1: continue with ±1 tracking after the search completes.
REQ-008 Port pd_valid, input, 1: pd_early is valid this cycle.
REQ-009 Port pd_early, input, 1: 1 = delay-line output leads the reference (more delay needed).
REQ-010 Port code, output, N_CODE: delay-cell chain select code.
REQ-011 Port busy, output, 1: binary search in progress.
REQ-012 Port done, output, 1: search complete; code is usable.
REQ-013 Port fail, output, 1: code is at a rail with the detector pushing beyond it.

Function
REQ-014 The block SHALL implement these states: IDLE, SETTLE, MEAS, DECIDE, DONE, plus a mode flag (SEARCH or TRACK).
REQ-015 In IDLE or DONE, start=1 SHALL do all of the following:
- clear done and fail;
- set the bit index to N_CODE-1 and code to only the MSB set;
- set mode to SEARCH and go to SETTLE.
REQ-016 In SETTLE, the block SHALL count SETTLE_CYC cycles, ignore pd inputs, then enter MEAS.
REQ-017 In MEAS, the block SHALL do all of the following:
- count only cycles with pd_valid=1;
- increment the early count when pd_valid and pd_early are both 1;
- enter DECIDE after N_AVG valid samples.
REQ-018 Vote rule: majority SHALL be early if and only if early count > N_AVG/2.
REQ-019 SEARCH decisions SHALL behave as follows:
- a late result, including a tie, clears the current bit;
- if the index is above 0, decrement it, set the next lower bit, and go to SETTLE;
- at index 0, set done=1, set fail=1 if code is 0 or all ones, and go to SETTLE in TRACK mode if track_en=1, else to DONE.
REQ-020 TRACK decisions SHALL behave as follows:
- early increments code, saturating at all ones;
- late decrements code, saturating at 0;
- a tie holds code;
- fail is set to 1 when saturation blocks a step, else 0;
- the block then returns to SETTLE.
REQ-021 busy SHALL be 1 exactly while mode=SEARCH and state is SETTLE, MEAS or DECIDE.
REQ-022 done SHALL stay 1 throughout TRACK and DONE.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 start during TRACK SHALL restart the search per REQ-015.
REQ-025 track_en=0 during TRACK SHALL move the block to DONE on the next edge with code held.
REQ-026 Search latency SHALL be N_CODE×(SETTLE_CYC+N_AVG+1) cycles when pd_valid is held high: 150 cycles at default parameters, from the edge that samples start to done=1.
REQ-027 code SHALL change only in DECIDE or on start acceptance.

Reset
REQ-028 rst=1 SHALL take effect immediately, also mid-search or mid-track, and force the following:
- state IDLE, mode SEARCH;
- code = midscale (MSB only; 32 at default parameters);
- busy=0, done=0, fail=0;
- all counters cleared.
REQ-029 The first state change after rst deasserts SHALL occur only on an edge where start=1.

Structure
REQ-030 The state enum, mode enum and default parameter constants SHALL reside in shared package dly_cal_pack.
REQ-031 Vote counting SHALL be a sub-module pd_vote_acc with these properties:
- inputs: clr, pd_valid, pd_early;
- outputs: sample count, early count, full flag;
- width log2(N_AVG)+1.
REQ-032 RTL SHALL be synthesizable; no delays or real types.

Verification (defaults; bench PD: pd_early = code ≤ T, pd_valid=1 unless noted)
REQ-033 T=22, start pulse, track_en=0 -> trial codes 32,16,24,20,22,23; final code=22; done=1 at cycle 150; busy high for cycles 1–150; fail=0.
REQ-034 pd_early stuck 1 -> code=63, fail=1; pd_early stuck 0 -> code=0, fail=1.
REQ-035 Exactly 8 of 16 votes early -> search clears the bit; in TRACK, code is unchanged.
REQ-036 Lock at 22 with track_en=1, then T=25 -> code 23, 24, 25, 26, then dithers 25/26 once every 25 cycles; done stays 1; track_en=0 -> DONE holding code.
REQ-037 pd_valid high every other cycle, T=22 -> final code=22; each MEAS phase lasts 32 cycles.
REQ-038 rst mid-MEAS -> code=32 and busy/done/fail=0 immediately; start while busy -> ignored, search result unchanged.

Source files
------------

// File: rtl/dly_cal_ctrl_pkg.sv
// Shared types and default parameters for the delay-line calibration controller.
package dly_cal_pack;

    localparam int DEF_N_CODE     = 6;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_N_AVG      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEAS,
        ST_DECIDE,
        ST_DONE
    } state_e;

    typedef enum logic {
        MODE_SEARCH,
        MODE_TRACK
    } mode_e;

endpackage

// File: rtl/dly_cal_ctrl_pd_vote_acc.sv
// Phase-detector vote accumulator: counts valid samples and early votes until
// N_AVG samples have been collected, then holds until cleared.
module pd_vote_acc #(
    parameter int N_AVG = 16,
    parameter int CW    = $clog2(N_AVG) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          pd_valid,
    input  logic          pd_early,
    output logic [CW-1:0] smp_cnt,
    output logic [CW-1:0] early_cnt,
    output logic          full
);

    logic [CW-1:0] smp_q;
    logic [CW-1:0] early_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q   <= '0;
            early_q <= '0;
        end else if (clr) begin
            smp_q   <= '0;
            early_q <= '0;
        end else if (pd_valid && !full) begin
            smp_q   <= smp_q + CW'(1);
            early_q <= early_q + {{(CW-1){1'b0}}, pd_early};
        end
    end

    assign full      = (smp_q == CW'(N_AVG));
    assign smp_cnt   = smp_q;
    assign early_cnt = early_q;

endmodule

// File: rtl/dly_cal_ctrl.sv
// Delay-line calibration: MSB-first binary search on the phase-detector majority
// vote, optionally followed by +/-1 tracking.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | delay line settling after a code change, pd ignored
// MEAS   | collecting N_AVG valid phase-detector votes
// DECIDE | apply search bit decision or tracking step
// DONE   | result held, waiting for start
module dly_cal_ctrl
    import dly_cal_pack::*;
#(
    parameter int N_CODE     = DEF_N_CODE,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int N_AVG      = DEF_N_AVG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              track_en,
    input  logic              pd_valid,
    input  logic              pd_early,
    output logic [N_CODE-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    localparam int IW = $clog2(N_CODE);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int CW = $clog2(N_AVG) + 1;
    localparam logic [N_CODE-1:0] CODE_MID = {1'b1, {(N_CODE-1){1'b0}}};
    localparam logic [N_CODE-1:0] CODE_MAX = '1;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [N_CODE-1:0] code_q, code_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;

    logic              acc_clr;
    logic              acc_vld;
    logic [CW-1:0]     smp_cnt;
    logic [CW-1:0]     early_cnt;
    logic              acc_full;
    logic              vote_early;
    logic              vote_tie;
    logic              in_loop;

    assign in_loop = (state_q == ST_SETTLE) || (state_q == ST_MEAS) || (state_q == ST_DECIDE);
    assign acc_clr = (state_q != ST_MEAS);
    assign acc_vld = pd_valid && (state_q == ST_MEAS);

    pd_vote_acc #(
        .N_AVG (N_AVG),
        .CW    (CW)
    ) u_vote_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .pd_valid  (acc_vld),
        .pd_early  (pd_early),
        .smp_cnt   (smp_cnt),
        .early_cnt (early_cnt),
        .full      (acc_full)
    );

    // Strict majority: an exact tie counts as late in search, hold in track.
    assign vote_early = acc_full && (early_cnt >  CW'(N_AVG / 2));
    assign vote_tie   = acc_full && (early_cnt == CW'(N_AVG / 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SEARCH;
            code_q   <= CODE_MID;
            idx_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        code_d   = code_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        done_d   = done_q;
        fail_d   = fail_q;

        if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                      (mode_q == MODE_TRACK && in_loop))) begin
            state_d  = ST_SETTLE;
            mode_d   = MODE_SEARCH;
            code_d   = CODE_MID;
            idx_d    = IW'(N_CODE - 1);
            settle_d = SW'(SETTLE_CYC - 1);
            done_d   = 1'b0;
            fail_d   = 1'b0;
        end else if (mode_q == MODE_TRACK && in_loop && !track_en) begin
            state_d = ST_DONE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == '0) state_d = ST_MEAS;
                    else                settle_d = settle_q - SW'(1);
                end
                ST_MEAS: begin
                    // Leave on the edge that registers the last vote so DECIDE sees a full count.
                    if (acc_vld && (smp_cnt == CW'(N_AVG - 1))) state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    state_d  = ST_SETTLE;
                    settle_d = SW'(SETTLE_CYC - 1);
                    if (mode_q == MODE_SEARCH) begin
                        if (!vote_early) code_d[idx_q] = 1'b0;
                        if (idx_q != '0) begin
                            idx_d                  = idx_q - IW'(1);
                            code_d[idx_q - IW'(1)] = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            fail_d = (code_d == '0) || (code_d == CODE_MAX);
                            if (track_en) mode_d  = MODE_TRACK;
                            else          state_d = ST_DONE;
                        end
                    end else if (vote_early) begin
                        fail_d = (code_q == CODE_MAX);
                        if (code_q != CODE_MAX) code_d = code_q + N_CODE'(1);
                    end else if (!vote_tie) begin
                        fail_d = (code_q == '0);
                        if (code_q != '0) code_d = code_q - N_CODE'(1);
                    end else begin
                        fail_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign code = code_q;
    assign busy = (mode_q == MODE_SEARCH) && in_loop;
    assign done = done_q;
    assign fail = fail_q;

endmodule
